serializador: RTL
=================

# serializador

Parallel-to-serial transmitter: the counterpart of the deserializer. It takes bytes from the queue's output side, pops them with a one-cycle dequeue strobe, and shifts each byte out MSB first on a single serial line. A write strobe qualifies every bit. It honours the receiver's busy flag between bytes and runs in the 100 kHz clock domain.

## Interface
- GAP, default 1 (legal values 1 to 15): minimum number of cycles `write_out` stays low between consecutive bytes.
- clk_100KHz  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  8  byte at the head of the source queue; sampled only on the accept edge.
- valid_in  input  1  source has a byte available (queue not empty).
- hold_in  input  1  receiver busy; while high, no new byte is accepted.
- dequeue_out  output  1  one-cycle pop strobe to the source queue.
- data_out  output  1  serial data bit.
- write_out  output  1  high while `data_out` carries a valid bit.
- status_out  output  1  high while a byte (including its gap) is in progress.

## Operation
- States:
  - IDLE: waiting for a byte.
  - SHIFT: emitting bits.
  - GAP: enforcing the inter-byte gap.
- Reset (asynchronous, reset=0):
  - state goes to IDLE.
  - Shift register and bit counter clear to 0.
  - All outputs go to 0: `dequeue_out`, `data_out`, `write_out`, `status_out`.
- IDLE:
  - Accept edge E: the first rising edge with valid_in=1 and hold_in=0.
  - On E: shift register loads `data_in`; `data_out` takes data_in[7]; `write_out`, `status_out` and `dequeue_out` go to 1; state goes to SHIFT.
  - If valid_in=0 or hold_in=1, the block stays in IDLE with all outputs 0.
- `dequeue_out` is high for exactly one cycle after E. It is never asserted outside an accept edge.
- SHIFT:
  - Each edge presents the next lower bit (bit 6 down to bit 0) on `data_out`.
  - A 3-bit counter tracks the position.
  - After bit 0 has been held for one cycle, `write_out` and `data_out` go to 0.
- After SHIFT ends:
  - GAP=1: state goes directly to IDLE.
  - GAP>1: state goes to GAP for GAP-1 cycles, then to IDLE.
  - `status_out` stays 1 until state returns to IDLE.
- `hold_in` is sampled only in IDLE. A byte in progress is never stalled or aborted by hold_in.
- `valid_in` and `data_in` are ignored outside IDLE.
- Reset mid-byte: transmission aborts immediately and outputs drop to 0. The popped byte is lost; this is accepted behaviour.

## Timing
- Latency: bit 7 is visible on `data_out` in the cycle after E.
- `write_out` is high for exactly 8 consecutive cycles (9 with parity), covering cycles E+1 through E+8.
- `write_out` falls at edge E+8 (E+9 with parity).
- With valid_in held 1 and hold_in 0, byte period is 8+GAP cycles (9+GAP with parity). `write_out` is low for exactly GAP cycles between bytes.
- `status_out` rises at E and falls on the edge that re-enters IDLE.
- `dequeue_out` and every byte's write burst are mutually consistent: one pop per transmitted byte, no pop without a following burst unless reset intervenes.

## Configuration
- SERIALIZADOR_PARITY_EN defined:
  - After bit 0, one extra bit is sent with write_out=1: even parity, i.e. XOR of the 8 data bits.
  - The counter runs to 8.
- Undefined: no parity bit; exactly 8 bits per byte.
- Ports and parameters are identical in both builds.

## Test plan
- Reset behaviour: assert reset=0 mid-SHIFT of byte 0xFF -> the same cycle shows `data_out`, `write_out`, `status_out` and `dequeue_out` at 0. After release with valid_in=0, all outputs stay 0.
- Single byte: data_in=0xA5, valid_in=1 for one accept -> one `dequeue_out` pulse; `data_out` = 1,0,1,0,0,1,0,1 on cycles E+1 to E+8 with write_out=1; write_out=0 at E+9.
- Back-to-back: bytes 0x3C then 0xC3 with GAP=1 -> second accept edge at E+9; exactly one low cycle on write_out between bursts; two `dequeue_out` pulses.
- Hold: hold_in=1 with valid_in=1 for 20 cycles -> no dequeue, write_out=0. hold_in raised mid-byte does not interrupt it. The next accept occurs on the first edge after hold_in=0.
- Gap parameter: GAP=4 with continuous valid_in -> write_out low for exactly 4 cycles between bytes; status_out high throughout the gap.
- Parity (macro on): byte 0x07 -> 9 write cycles, ninth bit = 1. Byte 0x03 -> ninth bit = 0.

Source files
------------

// File: rtl/serializador.sv
// Parallel-to-serial byte transmitter: pops a byte from the source queue and shifts it out MSB first.
// Optional even-parity bit appended after bit 0 when SERIALIZADOR_PARITY_EN is defined.
module serializador #(
    parameter int GAP = 1
) (
    input  logic       clk_100KHz,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    input  logic       hold_in,
    output logic       dequeue_out,
    output logic       data_out,
    output logic       write_out,
    output logic       status_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

`ifdef SERIALIZADOR_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif

    // The GAP state absorbs GAP-1 cycles; the IDLE cycle before the next accept supplies the last one.
    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);
    localparam logic       GAP_LONG = (GAP > 1);

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic [1:0] state_r,  state_s;
    logic [7:0] shreg_r,  shreg_s;
    logic [3:0] bitcnt_r, bitcnt_s;
    logic [3:0] gapcnt_r, gapcnt_s;
    logic       parity_r, parity_s;
    logic       dequeue_s;
    logic       data_s;
    logic       write_s;
    logic       status_s;

    // Next-state and next-output computation for the transmit sequencer.
    always_comb begin
        state_s   = state_r;
        shreg_s   = shreg_r;
        bitcnt_s  = bitcnt_r;
        gapcnt_s  = gapcnt_r;
        parity_s  = parity_r;
        dequeue_s = 1'b0;
        data_s    = data_out;
        write_s   = write_out;
        status_s  = status_out;
        case (state_r)
            ST_IDLE: begin
                if (valid_in && !hold_in) begin
                    state_s   = ST_SHIFT;
                    shreg_s   = data_in;
                    parity_s  = even_parity(data_in);
                    bitcnt_s  = 4'd0;
                    data_s    = data_in[7];
                    write_s   = 1'b1;
                    status_s  = 1'b1;
                    dequeue_s = 1'b1;
                end else begin
                    data_s    = 1'b0;
                    write_s   = 1'b0;
                    status_s  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (bitcnt_r == LAST_BIT) begin
                    data_s   = 1'b0;
                    write_s  = 1'b0;
                    bitcnt_s = 4'd0;
                    shreg_s  = 8'h00;
                    if (GAP_LONG) begin
                        state_s  = ST_GAP;
                        gapcnt_s = GAP_LOAD;
                        status_s = 1'b1;
                    end else begin
                        state_s  = ST_IDLE;
                        status_s = 1'b0;
                    end
                end else if (bitcnt_r == 4'd7) begin
                    // Only reachable when the parity bit is enabled.
                    data_s   = parity_r;
                    bitcnt_s = bitcnt_r + 4'd1;
                end else begin
                    data_s   = shreg_r[6];
                    shreg_s  = {shreg_r[6:0], 1'b0};
                    bitcnt_s = bitcnt_r + 4'd1;
                end
            end
            ST_GAP: begin
                if (gapcnt_r <= 4'd1) begin
                    state_s  = ST_IDLE;
                    gapcnt_s = 4'd0;
                    status_s = 1'b0;
                end else begin
                    gapcnt_s = gapcnt_r - 4'd1;
                    status_s = 1'b1;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                shreg_s  = 8'h00;
                bitcnt_s = 4'd0;
                gapcnt_s = 4'd0;
                parity_s = 1'b0;
                data_s   = 1'b0;
                write_s  = 1'b0;
                status_s = 1'b0;
            end
        endcase
    end

    // State and registered-output update; reset aborts any byte in flight.
    always_ff @(posedge clk_100KHz or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            shreg_r     <= 8'h00;
            bitcnt_r    <= 4'd0;
            gapcnt_r    <= 4'd0;
            parity_r    <= 1'b0;
            dequeue_out <= 1'b0;
            data_out    <= 1'b0;
            write_out   <= 1'b0;
            status_out  <= 1'b0;
        end else begin
            state_r     <= state_s;
            shreg_r     <= shreg_s;
            bitcnt_r    <= bitcnt_s;
            gapcnt_r    <= gapcnt_s;
            parity_r    <= parity_s;
            dequeue_out <= dequeue_s;
            data_out    <= data_s;
            write_out   <= write_s;
            status_out  <= status_s;
        end
    end

endmodule
